// File: rtl/sqrt_newton_ctrl_if.sv
// Bundle of the controller's datapath-side signals.
//   start_i     : begin a computation (operand n on the datapath input bus)
//   n_zero_i    : operand is +/-0, sampled with start_i
//   alu_done_i  : FP ALU result valid and held
//   conv_i      : comparator |RDA| < RDB
//   rf_we_o, rf_addr_wr_o, rf_addr_rda_o, rf_addr_rdb_o : register-file control
//   wb_sel_o    : write-data source, 0 = external input, 1 = ALU result
//   alu_op_o    : 00 add, 01 sub, 10 mul, 11 div
//   alu_start_o : one-cycle ALU launch pulse
//   busy_o, done_o, err_o, iter_o : status
//   dbg_state_o : controller FSM state, for observation only
// master = controller side, slave = datapath side.
interface sqrt_newton_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int ITER_W     = 5
) ();
  logic                  start_i;
  logic                  n_zero_i;
  logic                  alu_done_i;
  logic                  conv_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_addr_wr_o;
  logic [ADDR_WIDTH-1:0] rf_addr_rda_o;
  logic [ADDR_WIDTH-1:0] rf_addr_rdb_o;
  logic                  wb_sel_o;
  logic [1:0]            alu_op_o;
  logic                  alu_start_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [ITER_W-1:0]     iter_o;
  logic [3:0]            dbg_state_o;

  modport master (
    input  start_i, n_zero_i, alu_done_i, conv_i,
    output rf_we_o, rf_addr_wr_o, rf_addr_rda_o, rf_addr_rdb_o, wb_sel_o,
           alu_op_o, alu_start_o, busy_o, done_o, err_o, iter_o, dbg_state_o
  );

  modport slave (
    output start_i, n_zero_i, alu_done_i, conv_i,
    input  rf_we_o, rf_addr_wr_o, rf_addr_rda_o, rf_addr_rdb_o, wb_sel_o,
           alu_op_o, alu_start_o, busy_o, done_o, err_o, iter_o, dbg_state_o
  );
endinterface

// File: rtl/sqrt_newton_ctrl.sv
// Sequencing FSM for the floating-point square-root datapath (Newton iteration
// root = (x + n/x)/2 until |root - x| < eps, result written to R7).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sqrt_newton_ctrl_if.master (handshake, register-file and ALU control,
//         status and debug state)
// Register map: R0=0, R1=n, R2=x, R3=root, R4=temp, R5=2.0, R6=eps, R7=result.
// Handshake: start_i is accepted only in IDLE/DONE; alu_start_o is a one-cycle
// launch in GO, and alu_done_i is only looked at in WAIT, so a done level still
// held from the previous op can never short-circuit a step.
module sqrt_newton_ctrl #(
  parameter int MAX_ITER   = 16,
  parameter int ITER_W     = 5,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  sqrt_newton_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LD_N    = 4'd1,
    ST_LD_X    = 4'd2,
    ST_RD      = 4'd3,
    ST_GO      = 4'd4,
    ST_WAIT    = 4'd5,
    ST_WB      = 4'd6,
    ST_CMP_RD  = 4'd7,
    ST_CMP_CHK = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  // Which micro-op the RD/GO/WAIT/WB walk is executing.
  typedef enum logic [2:0] {
    SP_DIV_NX = 3'd0,  // R4 = R1 / R2
    SP_ADD_X  = 3'd1,  // R4 = R2 + R4
    SP_HALF   = 3'd2,  // R3 = R4 / R5
    SP_DIFF   = 3'd3,  // R4 = R3 - R2
    SP_COPY   = 3'd4,  // R2 = R3 + R0
    SP_FIN    = 3'd5,  // R7 = R3 + R0
    SP_FIN_Z  = 3'd6   // R7 = R1 + R0
  } step_t;

  localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] R1 = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] R2 = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] R3 = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] R4 = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] R5 = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] R6 = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] R7 = ADDR_WIDTH'(7);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t            r_state;
  step_t             r_step;
  logic              r_done;
  logic              r_err;
  logic [ITER_W-1:0] r_iter;

  state_t                w_state_nx;
  step_t                 w_step_nx;
  logic                  w_start_acc;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_wr;
  logic [ADDR_WIDTH-1:0] w_rda;
  logic [ADDR_WIDTH-1:0] w_rdb;
  logic                  w_wb_sel;
  logic [1:0]            w_op;
  logic                  w_alu_start;
  logic                  w_busy;
  logic                  w_protected;

  logic [1:0]            w_step_op;
  logic [ADDR_WIDTH-1:0] w_step_a;
  logic [ADDR_WIDTH-1:0] w_step_b;
  logic [ADDR_WIDTH-1:0] w_step_w;

  logic [ITER_W-1:0]     w_iter_inc;
  logic                  w_limit;

  assign w_iter_inc = r_iter + ITER_W'(1);
  assign w_limit    = (w_iter_inc == ITER_W'(MAX_ITER));

  // Micro-op table.
  always_comb begin
    w_step_op = OP_ADD;
    w_step_a  = R0;
    w_step_b  = R0;
    w_step_w  = R4;
    case (r_step)
      SP_DIV_NX: begin w_step_op = OP_DIV; w_step_a = R1; w_step_b = R2; w_step_w = R4; end
      SP_ADD_X:  begin w_step_op = OP_ADD; w_step_a = R2; w_step_b = R4; w_step_w = R4; end
      SP_HALF:   begin w_step_op = OP_DIV; w_step_a = R4; w_step_b = R5; w_step_w = R3; end
      SP_DIFF:   begin w_step_op = OP_SUB; w_step_a = R3; w_step_b = R2; w_step_w = R4; end
      SP_COPY:   begin w_step_op = OP_ADD; w_step_a = R3; w_step_b = R0; w_step_w = R2; end
      SP_FIN:    begin w_step_op = OP_ADD; w_step_a = R3; w_step_b = R0; w_step_w = R7; end
      SP_FIN_Z:  begin w_step_op = OP_ADD; w_step_a = R1; w_step_b = R0; w_step_w = R7; end
      default:   ;
    endcase
  end

  // Next-state and outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_step_nx   = r_step;
    w_start_acc = 1'b0;
    w_we        = 1'b0;
    w_wr        = R0;
    w_rda       = R0;
    w_rdb       = R0;
    w_wb_sel    = 1'b0;
    w_op        = OP_ADD;
    w_alu_start = 1'b0;
    w_busy      = 1'b1;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_busy = 1'b0;
        if (bus.start_i) begin
          w_start_acc = 1'b1;
          w_state_nx  = ST_LD_N;
          // The zero path still loads R1 (bus holds 0) and then copies it out.
          w_step_nx   = bus.n_zero_i ? SP_FIN_Z : SP_DIV_NX;
        end
      end
      ST_LD_N: begin
        w_we       = 1'b1;
        w_wr       = R1;
        w_state_nx = (r_step == SP_FIN_Z) ? ST_RD : ST_LD_X;
      end
      ST_LD_X: begin
        w_we       = 1'b1;
        w_wr       = R2;
        w_state_nx = ST_RD;
      end
      ST_RD, ST_GO, ST_WAIT, ST_WB: begin
        // Addresses and op stay constant across the whole micro-op.
        w_wr  = w_step_w;
        w_rda = w_step_a;
        w_rdb = w_step_b;
        w_op  = w_step_op;
        case (r_state)
          ST_RD:   w_state_nx = ST_GO;
          ST_GO: begin
            w_alu_start = 1'b1;
            w_state_nx  = ST_WAIT;
          end
          ST_WAIT: if (bus.alu_done_i) w_state_nx = ST_WB;
          default: begin
            w_we     = 1'b1;
            w_wb_sel = 1'b1;
            case (r_step)
              SP_DIV_NX: begin w_step_nx = SP_ADD_X;  w_state_nx = ST_RD; end
              SP_ADD_X:  begin w_step_nx = SP_HALF;   w_state_nx = ST_RD; end
              SP_HALF:   begin w_step_nx = SP_DIFF;   w_state_nx = ST_RD; end
              SP_DIFF:   w_state_nx = ST_CMP_RD;
              SP_COPY:   begin w_step_nx = SP_DIV_NX; w_state_nx = ST_RD; end
              default:   w_state_nx = ST_DONE;
            endcase
          end
        endcase
      end
      ST_CMP_RD, ST_CMP_CHK: begin
        w_rda = R4;
        w_rdb = R6;
        if (r_state == ST_CMP_RD) begin
          w_state_nx = ST_CMP_CHK;
        end else begin
          w_state_nx = ST_RD;
          // Convergence takes priority over the iteration limit.
          w_step_nx  = (bus.conv_i || w_limit) ? SP_FIN : SP_COPY;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Hard guard for the constant registers, independent of the step table.
  assign w_protected = (w_wr == R0) || (w_wr == R5) || (w_wr == R6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= SP_DIV_NX;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      if (w_start_acc) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_iter <= '0;
      end
      if (r_state == ST_CMP_CHK) begin
        r_iter <= w_iter_inc;
        if (!bus.conv_i && w_limit) r_err <= 1'b1;
      end
      if (r_state == ST_WB && (r_step == SP_FIN || r_step == SP_FIN_Z)) r_done <= 1'b1;
    end
  end

  assign bus.rf_we_o       = w_we && !w_protected;
  assign bus.rf_addr_wr_o  = w_wr;
  assign bus.rf_addr_rda_o = w_rda;
  assign bus.rf_addr_rdb_o = w_rdb;
  assign bus.wb_sel_o      = w_wb_sel;
  assign bus.alu_op_o      = w_op;
  assign bus.alu_start_o   = w_alu_start;
  assign bus.busy_o        = w_busy;
  assign bus.done_o        = r_done;
  assign bus.err_o         = r_err;
  assign bus.iter_o        = r_iter;
  assign bus.dbg_state_o   = r_state;

endmodule

// File: tb/tb_sqrt_newton_ctrl.sv
// Directed bench for sqrt_newton_ctrl with a float32 register-file/ALU model.
// Two controllers share the model: dut_a (MAX_ITER=16) and dut_b (MAX_ITER=2);
// sel picks which one drives the model.
module tb_sqrt_newton_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus state ----------------
  logic        sel     = 1'b0;
  logic        start   = 1'b0;
  logic        n_zero  = 1'b0;
  logic [31:0] din     = 32'h0;
  int          alu_lat = 1;

  int n_asrt = 0;
  int n_fail = 0;

  sqrt_newton_ctrl_if #(.ADDR_WIDTH(3), .ITER_W(5)) bus_a ();
  sqrt_newton_ctrl_if #(.ADDR_WIDTH(3), .ITER_W(5)) bus_b ();

  sqrt_newton_ctrl #(.MAX_ITER(16), .ITER_W(5), .ADDR_WIDTH(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sqrt_newton_ctrl #(.MAX_ITER(2),  .ITER_W(5), .ADDR_WIDTH(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- datapath model ----------------
  logic        w_alu_done;
  logic        w_conv;
  logic        m_we, m_wbsel, m_astart, m_busy, m_done, m_err;
  logic [2:0]  m_wr, m_rda, m_rdb;
  logic [1:0]  m_op;
  logic [4:0]  m_iter;

  assign bus_a.start_i    = start & ~sel;
  assign bus_b.start_i    = start & sel;
  assign bus_a.n_zero_i   = n_zero & ~sel;
  assign bus_b.n_zero_i   = n_zero & sel;
  assign bus_a.alu_done_i = w_alu_done;
  assign bus_b.alu_done_i = w_alu_done;
  assign bus_a.conv_i     = w_conv;
  assign bus_b.conv_i     = w_conv;

  assign m_we     = sel ? bus_b.rf_we_o       : bus_a.rf_we_o;
  assign m_wr     = sel ? bus_b.rf_addr_wr_o  : bus_a.rf_addr_wr_o;
  assign m_rda    = sel ? bus_b.rf_addr_rda_o : bus_a.rf_addr_rda_o;
  assign m_rdb    = sel ? bus_b.rf_addr_rdb_o : bus_a.rf_addr_rdb_o;
  assign m_wbsel  = sel ? bus_b.wb_sel_o      : bus_a.wb_sel_o;
  assign m_op     = sel ? bus_b.alu_op_o      : bus_a.alu_op_o;
  assign m_astart = sel ? bus_b.alu_start_o   : bus_a.alu_start_o;
  assign m_busy   = sel ? bus_b.busy_o        : bus_a.busy_o;
  assign m_done   = sel ? bus_b.done_o        : bus_a.done_o;
  assign m_err    = sel ? bus_b.err_o         : bus_a.err_o;
  assign m_iter   = sel ? bus_b.iter_o        : bus_a.iter_o;

  function automatic real b2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2b(input real v);
    real        a;
    int         e;
    longint     m;
    logic       s;
    logic [7:0] ex;
    logic [22:0] mt;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = longint'((a - 1.0) * 8388608.0);
    if (m >= 64'sd8388608) begin m = 0; e++; end
    ex = 8'(e + 127);
    mt = 23'(m);
    return {s, ex, mt};
  endfunction

  function automatic logic [31:0] alu_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    real x, y, r;
    x = b2r(a);
    y = b2r(b);
    case (op)
      2'b00:   r = x + y;
      2'b01:   r = x - y;
      2'b10:   r = x * y;
      default: r = (y == 0.0) ? 0.0 : x / y;
    endcase
    return r2b(r);
  endfunction

  logic [31:0] rf [8];
  logic [31:0] rd_a, rd_b, alu_res;
  int          alu_cnt;
  logic        alu_val, fresh;
  int          starts  = 0;
  int          bad_wr  = 0;
  int          early   = 0;
  logic [2:0]  wq[$];

  // R0, R5, R6 are constants of the datapath.
  function automatic logic [31:0] rf_read(input logic [2:0] ad);
    case (ad)
      3'd0:    return 32'h0000_0000;
      3'd5:    return 32'h4000_0000;
      3'd6:    return 32'h3727_C5AC;
      default: return rf[ad];
    endcase
  endfunction

  assign w_alu_done = alu_val && (alu_cnt == 0);

  always_comb begin
    real ra;
    ra = b2r(rd_a);
    if (ra < 0.0) ra = -ra;
    w_conv = (ra < b2r(rd_b));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_val <= 1'b0;
      alu_cnt <= 0;
      fresh   <= 1'b0;
      rd_a    <= 32'h0;
      rd_b    <= 32'h0;
      alu_res <= 32'h0;
    end else begin
      rd_a <= rf_read(m_rda);
      rd_b <= rf_read(m_rdb);
      if (m_astart) begin
        alu_res <= alu_calc(m_op, rd_a, rd_b);
        alu_cnt <= alu_lat - 1;
        alu_val <= 1'b1;
        fresh   <= 1'b1;
        starts  <= starts + 1;
      end else if (alu_cnt != 0) begin
        alu_cnt <= alu_cnt - 1;
      end
      if (m_we) begin
        wq.push_back(m_wr);
        if (m_wr == 3'd0 || m_wr == 3'd5 || m_wr == 3'd6) bad_wr <= bad_wr + 1;
        if (m_wbsel) begin
          if (!(fresh && alu_cnt == 0)) early <= early + 1;
          fresh <= 1'b0;
        end
        rf[m_wr] <= m_wbsel ? alu_res : din;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic b, input logic [31:0] n, input logic nz, input int lat);
    @(negedge clk);
    sel = b; din = n; n_zero = nz; alu_lat = lat; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n_zero = 1'b0;
    chk("start_busy", {31'd0, m_busy}, 32'd1);
    chk("start_done_clr", {31'd0, m_done}, 32'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      cyc++;
      if (m_done) break;
    end
    chk("done_reached", {31'd0, m_done}, 32'd1);
  endtask

  task automatic wait_go();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_astart) break;
    end
    chk("go_seen", {31'd0, m_astart}, 32'd1);
  endtask

  task automatic check_seq(input string tag, input int base, input int iters, input logic zpath);
    logic [2:0] exp_q[$];
    int         bad, len;
    exp_q = {};
    exp_q.push_back(3'd1);
    if (!zpath) begin
      exp_q.push_back(3'd2);
      for (int k = 1; k <= iters; k++) begin
        exp_q.push_back(3'd4); exp_q.push_back(3'd4);
        exp_q.push_back(3'd3); exp_q.push_back(3'd4);
        if (k < iters) exp_q.push_back(3'd2);
      end
    end
    exp_q.push_back(3'd7);
    len = wq.size() - base;
    bad = 0;
    for (int i = 0; i < len && i < exp_q.size(); i++)
      if (wq[base + i] !== exp_q[i]) bad++;
    chk({tag, "_wr_len"}, len, exp_q.size());
    chk({tag, "_wr_addr_errs"}, bad, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         cyc, base, st0, bw0, ea0;
    real        r;
    logic [2:0] first6[6];
    first6 = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd3, 3'd4};

    repeat (3) @(negedge clk);
    chk("reset_outs_a", {6'd0, bus_a.rf_we_o, bus_a.rf_addr_wr_o, bus_a.rf_addr_rda_o, bus_a.rf_addr_rdb_o,
        bus_a.wb_sel_o, bus_a.alu_op_o, bus_a.alu_start_o, bus_a.busy_o, bus_a.done_o, bus_a.err_o,
        bus_a.iter_o, bus_a.dbg_state_o}, 32'd0);
    chk("reset_outs_b", {6'd0, bus_b.rf_we_o, bus_b.rf_addr_wr_o, bus_b.rf_addr_rda_o, bus_b.rf_addr_rdb_o,
        bus_b.wb_sel_o, bus_b.alu_op_o, bus_b.alu_start_o, bus_b.busy_o, bus_b.done_o, bus_b.err_o,
        bus_b.iter_o, bus_b.dbg_state_o}, 32'd0);
    rst = 1'b0;

    // n = 16.0, latency 1
    base = wq.size(); st0 = starts; bw0 = bad_wr; ea0 = early;
    launch(1'b0, 32'h4180_0000, 1'b0, 1);
    wait_done(cyc);
    chk("n16_r7", rf[7], 32'h4080_0000);
    chk("n16_err", {31'd0, m_err}, 32'd0);
    chk("n16_busy_done", {31'd0, m_busy}, 32'd0);
    for (int i = 0; i < 6; i++) chk($sformatf("n16_wr%0d", i), {29'd0, wq[base + i]}, {29'd0, first6[i]});
    check_seq("n16", base, int'(m_iter), 1'b0);
    chk("n16_starts", starts - st0, 5 * int'(m_iter));
    chk("n16_bad_wr", bad_wr - bw0, 0);
    chk("n16_early_wb", early - ea0, 0);

    // n = 2.0, latency 5, spurious start during WAIT
    base = wq.size(); st0 = starts; bw0 = bad_wr; ea0 = early;
    launch(1'b0, 32'h4000_0000, 1'b0, 5);
    wait_go();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wait_start_busy", {31'd0, m_busy}, 32'd1);
    wait_done(cyc);
    r = b2r(rf[7]);
    chk("n2_r7_tol", {31'd0, (r > 1.41421356 - 1.0e-5) && (r < 1.41421356 + 1.0e-5)}, 32'd1);
    chk("n2_err", {31'd0, m_err}, 32'd0);
    check_seq("n2", base, int'(m_iter), 1'b0);
    chk("n2_starts", starts - st0, 5 * int'(m_iter));
    chk("n2_bad_wr", bad_wr - bw0, 0);
    chk("n2_early_wb", early - ea0, 0);

    // n = 0 with n_zero, latency 1
    base = wq.size();
    launch(1'b0, 32'h0000_0000, 1'b1, 1);
    wait_done(cyc);
    chk("zero_r7", rf[7], 32'h0);
    chk("zero_iter", {27'd0, m_iter}, 32'd0);
    chk("zero_latency_ok", {31'd0, (cyc + 1) <= 7}, 32'd1);
    check_seq("zero", base, 0, 1'b1);

    // MAX_ITER = 2, n = 1e6
    base = wq.size(); bw0 = bad_wr;
    launch(1'b1, 32'h4974_2400, 1'b0, 1);
    wait_done(cyc);
    chk("lim_err", {31'd0, m_err}, 32'd1);
    chk("lim_done", {31'd0, m_done}, 32'd1);
    chk("lim_iter", {27'd0, m_iter}, 32'd2);
    chk("lim_r7", rf[7], 32'h4874_2450);
    check_seq("lim", base, 2, 1'b0);
    chk("lim_bad_wr", bad_wr - bw0, 0);

    // Reset during WAIT on dut_a, then a normal run
    launch(1'b0, 32'h4180_0000, 1'b0, 3);
    wait_go();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_outs", {6'd0, bus_a.rf_we_o, bus_a.rf_addr_wr_o, bus_a.rf_addr_rda_o, bus_a.rf_addr_rdb_o,
        bus_a.wb_sel_o, bus_a.alu_op_o, bus_a.alu_start_o, bus_a.busy_o, bus_a.done_o, bus_a.err_o,
        bus_a.iter_o, bus_a.dbg_state_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = wq.size(); st0 = starts;
    launch(1'b0, 32'h4180_0000, 1'b0, 2);
    wait_done(cyc);
    chk("after_rst_r7", rf[7], 32'h4080_0000);
    chk("after_rst_err", {31'd0, m_err}, 32'd0);
    check_seq("after_rst", base, int'(m_iter), 1'b0);
    chk("after_rst_starts", starts - st0, 5 * int'(m_iter));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required $finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
